// File: rtl/kamus_pipe_ctrl.sv
// Hazard/sequencing controller for the IF/ID/EX pipeline: PC enable plus IF/ID and ID/EX enable/flush.
// Define KAMUS_PIPE_CTRL_PERF_EN to add the stall_cnt_o/flush_cnt_o performance counters.
module kamus_pipe_ctrl #(
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       imem_valid_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic       ex_valid_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_is_load_i,
    input  logic       ex_busy_i,
    input  logic       ex_redirect_i,
    output logic       pc_en_o,
    output logic       ifid_en_o,
    output logic       ifid_flush_o,
    output logic       idex_en_o,
    output logic       idex_flush_o,
    output logic [1:0] state_o
`ifdef KAMUS_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        FLUSH  = 2'd2,
        EXWAIT = 2'd3
    } state_t;

    if (LOAD_LATENCY < 1 || LOAD_LATENCY > 7) begin : g_bad_load_latency
        $error("kamus_pipe_ctrl: LOAD_LATENCY must be in 1..7");
    end
    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("kamus_pipe_ctrl: FLUSH_CYCLES must be in 0..7");
    end

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_LATENCY - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       load_use;
    logic       run_eval;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;

    assign load_use = ex_valid_i && ex_is_load_i && id_valid_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    // Redirect/busy pre-empt a load-use countdown, and a finished multi-cycle op re-enters normal evaluation.
    assign run_eval = (state == RUN) ||
                      ((state == LDUSE) && (ex_redirect_i || ex_busy_i)) ||
                      ((state == EXWAIT) && (ex_redirect_i || !ex_busy_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        state_next = state;
        cnt_next   = cnt;
        if (run_eval) begin
            if (ex_redirect_i) begin
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_next = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
                cnt_next   = FL_RELOAD;
            end else if (ex_busy_i) begin
                state_next = EXWAIT;
                cnt_next   = 3'd0;
            end else if (load_use) begin
                idex_flush = 1'b1;
                state_next = (LOAD_LATENCY == 1) ? RUN : LDUSE;
                cnt_next   = LU_RELOAD;
            end else if (!imem_valid_i) begin
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                state_next = RUN;
                cnt_next   = 3'd0;
            end else begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                state_next = RUN;
                cnt_next   = 3'd0;
            end
        end else begin
            case (state)
                LDUSE: begin
                    idex_flush = 1'b1;
                    if (cnt <= 3'd1) begin
                        state_next = RUN;
                        cnt_next   = 3'd0;
                    end else begin
                        cnt_next = cnt - 3'd1;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (ex_redirect_i) begin
                        pc_en    = 1'b1;
                        cnt_next = FL_RELOAD;
                    end else begin
                        pc_en = imem_valid_i;
                        // Only fetches that actually return count toward draining the L1I latency.
                        if (imem_valid_i) begin
                            if (cnt <= 3'd1) begin
                                state_next = RUN;
                                cnt_next   = 3'd0;
                            end else begin
                                cnt_next = cnt - 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    assign pc_en_o      = rst_ni & pc_en;
    assign ifid_en_o    = rst_ni & ifid_en;
    assign idex_en_o    = rst_ni & idex_en;
    assign ifid_flush_o = ~rst_ni | ifid_flush;
    assign idex_flush_o = ~rst_ni | idex_flush;
    assign state_o      = state;

`ifdef KAMUS_PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (!pc_en_o && !ifid_flush_o && !idex_flush_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (idex_flush_o) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/kamus_pipe_ctrl.md
Name: kamus_pipe_ctrl

Overview:
- Central hazard and sequencing controller for the in-order IF/ID/EX pipeline.
- Drives the PC enable and the enable/flush of the IF/ID and ID/EX pipeline registers from:
  - fetch readiness,
  - ID source-register usage,
  - EX load/multi-cycle status,
  - EX branch/jump redirects.
- Sits beside the stages in the core top and owns no datapath state; its only state is a small FSM plus counters.

Parameters:
- LOAD_LATENCY, 1, bubbles inserted on a load-use hazard (1..7).
- FLUSH_CYCLES, 1, extra cycles IF/ID is flushed after a redirect to cover L1I latency (0..7).

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset; asynchronous, active-low
- imem_valid_i  in  1  L1I data valid for the current PC
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_addr_i  in  5  ID source 1 address
- id_rs2_addr_i  in  5  ID source 2 address
- id_rs1_used_i  in  1  ID reads rs1
- id_rs2_used_i  in  1  ID reads rs2
- ex_valid_i  in  1  EX holds a real instruction
- ex_rd_addr_i  in  5  EX destination address
- ex_is_load_i  in  1  EX instruction is a load
- ex_busy_i  in  1  EX multi-cycle operation not finished
- ex_redirect_i  in  1  taken branch/jump resolved in EX this cycle
- pc_en_o  out  1  PC register update enable
- ifid_en_o  out  1  IF/ID register capture enable
- ifid_flush_o  out  1  IF/ID loads a bubble (wins over en)
- idex_en_o  out  1  ID/EX register capture enable
- idex_flush_o  out  1  ID/EX loads a bubble (wins over en)
- state_o  out  2  FSM state: RUN=0, LDUSE=1, FLUSH=2, EXWAIT=3

Behaviour:
- Reset:
  - While rst_ni=0: state=RUN, counter=0.
  - All enables are 0 and both flushes are 1, gated combinationally on rst_ni.
  - Reset asserted in any state returns to RUN immediately and aborts any pending count.
- All outputs are combinational from the current state and inputs; zero-latency reaction.
- Load-use hazard (LU) is true when all of the following hold:
  - ex_valid_i, ex_is_load_i and id_valid_i are 1;
  - ex_rd_addr_i != 0;
  - (id_rs1_used_i and rs1==rd) or (id_rs2_used_i and rs2==rd).
- Event priority per cycle: ex_redirect_i > ex_busy_i > LU > !imem_valid_i > normal.
- RUN state:
  - Redirect: pc_en=1, ifid_flush=1, idex_flush=1. Next state is FLUSH with cnt=FLUSH_CYCLES, or RUN if FLUSH_CYCLES=0.
  - Busy: pc_en=0, ifid_en=0, idex_en=0, no flush. Next state is EXWAIT.
  - LU: pc_en=0, ifid_en=0, idex_flush=1. Next state is LDUSE with cnt=LOAD_LATENCY-1, or RUN if LOAD_LATENCY=1.
  - !imem_valid_i: pc_en=0, ifid_flush=1, idex_en=1 (bubble enters ID; downstream advances).
  - Otherwise: all enables 1, no flush.
- LDUSE state:
  - Outputs as for LU; cnt decrements each cycle; leave to RUN in the cycle cnt reaches 0.
  - A redirect or busy seen here is handled as in RUN, overriding the remaining count.
- FLUSH state:
  - ifid_flush=1, idex_flush=1, and pc_en=imem_valid_i.
  - cnt decrements only when imem_valid_i=1; go to RUN in the cycle cnt reaches 0.
  - A new redirect reloads cnt=FLUSH_CYCLES.
- EXWAIT state:
  - All enables 0, no flush, while ex_busy_i=1.
  - When ex_busy_i falls, the cycle is evaluated as in RUN.
  - A redirect while busy is still taken.
- Counters:
  - 3-bit, never underflow.
  - Parameter values outside their range are a compile-time error (static assertion).

Optional Feature:
- Macro KAMUS_PIPE_CTRL_PERF_EN.
- When defined, adds output ports:
  - stall_cnt_o [31:0], counting cycles with pc_en_o=0 and no flush;
  - flush_cnt_o [31:0], counting cycles with idex_flush_o=1.
- Both counters reset to 0, wrap at 2^32 and count only while rst_ni=1.
- When undefined, these ports and their logic are absent.

Test Plan:
- Reset release, all inputs idle, imem_valid_i=1 -> state_o=0; pc_en, ifid_en and idex_en =1 from the first cycle; flushes 0.
- Load in EX (rd=5) with ID using rs2=5, LOAD_LATENCY=2 -> exactly 2 cycles of pc_en=0, ifid_en=0, idex_flush=1, then RUN; with rd=0 -> no stall.
- ex_redirect_i pulse, FLUSH_CYCLES=1, imem_valid_i low for 3 cycles -> FLUSH holds ifid_flush=1 for 4 cycles, then RUN.
- ex_busy_i high 10 cycles with ex_redirect_i on cycle 4 -> 3 hold cycles, then the flush cycle, then FLUSH state.
- rst_ni asserted mid-LDUSE -> immediate state_o=0, enables 0, both flushes 1; on release, normal RUN.
- With KAMUS_PIPE_CTRL_PERF_EN: 5 busy cycles plus 1 redirect (FLUSH_CYCLES=1) -> stall_cnt_o=5, flush_cnt_o=2.
